array_result_drain: RTL and testbench
=====================================

# array_result_drain

- Sits downstream of the 4x4 PE array.
- On a completion pulse, captures all BLOCK_SIZE*ARRAY_SIZE accumulator lanes (Array_Output, 32-bit each) in one cycle.
- Streams the captured lanes to the output buffer over a valid/ready handshake, in one of two modes:
  - raw mode: one full-width accumulator word per lane;
  - packed mode: ReLU, right-shift and saturate each lane to 8 bits, four lanes per word.

## Interface

Parameters:

- DATA_WIDTH, 8, activation/quantized output width
- ACC_WIDTH, 32 (4*DATA_WIDTH), accumulator lane width and output word width
- LANES, 16 (BLOCK_SIZE*ARRAY_SIZE), number of array output lanes; must be a multiple of 4

Ports (one clock; reset is asynchronous and active-high, port names Clk and Rst):

- Clk  input  1  clock, rising edge
- Rst  input  1  asynchronous active-high reset
- Array_Output  input  LANES*ACC_WIDTH  flattened lanes; lane i at [ACC_WIDTH*(i+1)-1 : ACC_WIDTH*i], signed two's complement
- Result_valid  input  1  one-cycle pulse: Array_Output holds final results this cycle
- Out_mode  input  1  0 = raw, 1 = packed; sampled at capture
- Shift  input  5  right-shift amount for packed mode; sampled at capture
- Out_data  output  ACC_WIDTH  current output word
- Out_valid  output  1  Out_data valid
- Out_ready  input  1  downstream accepts word when Out_valid && Out_ready
- Out_last  output  1  high with the final word of a frame
- Busy  output  1  frame captured and not fully drained
- Overrun  output  1  one-cycle pulse: Result_valid dropped

## Operation

- FSM states:
  - IDLE: Busy=0, Out_valid=0.
  - SEND: Busy=1, Out_valid=1.
- IDLE -> SEND when Result_valid=1:
  - all LANES lanes, Out_mode and Shift are registered; word index is cleared to 0.
- SEND: a word is transferred on each cycle with Out_valid && Out_ready, and the index then increments.
  - On the final word's transfer, go to IDLE; if Result_valid=1 in that same cycle, capture the new frame and stay in SEND with index 0.
- Result_valid in SEND other than on the final-transfer cycle is ignored: the frame in flight is untouched and Overrun pulses for 1 cycle.
- Raw mode:
  - LANES words per frame; word k = lane k unchanged.
  - Out_last on word LANES-1.
- Packed mode:
  - LANES/4 words per frame; word k holds lane 4k in bits [7:0], 4k+1 in [15:8], 4k+2 in [23:16], 4k+3 in [31:24].
  - Out_last on word LANES/4-1.
- Per-lane quantization (packed mode only):
  - if lane < 0, result = 0;
  - else t = lane >> Shift (logical, truncating); result = (t > 255) ? 255 : t[7:0].
  - Quantization uses the sampled Shift, so a Shift change mid-frame has no effect.
- Out_data is selected/quantized from the registered lanes and captured mode.
  - Out_data and Out_last must stay stable while Out_valid && !Out_ready.
- Out_data is 0 whenever Out_valid=0.

## Timing

- Reset (async assert, any state): state=IDLE, Out_valid=0, Out_last=0, Out_data=0, Busy=0, Overrun=0, index=0. A frame in flight is discarded with no partial Out_last.
- Capture latency: Result_valid sampled at edge N gives Out_valid=1 with word 0 from after edge N.
- Throughput with Out_ready held 1:
  - raw mode: LANES words in LANES consecutive cycles;
  - packed mode: LANES/4 words in LANES/4 cycles.
- Back-to-back frames: zero bubble cycles when Result_valid coincides with the final transfer.
- Out_ready=0 stalls indefinitely with no data loss.
- Overrun is registered and asserts in the cycle after the dropped pulse.
- Out_ready is ignored in IDLE.
- Out_mode and Shift are don't-care outside the capture cycle.

## Test plan

- **Reset mid-frame:**
  - Stimulus: capture a raw frame, transfer 3 words, assert Rst for 1 cycle.
  - Response: Out_valid, Busy and Out_last go 0 at once and no further words appear.
  - A new Result_valid afterwards restarts at lane 0.
- **Raw drain with stalls:**
  - Stimulus: lane i = 1000+i, Out_mode=0; Out_ready toggles 1,0,1,0…
  - Response: 16 words 1000..1015 in order, each held stable during stalls; Out_last only on 1015; Busy falls after the last transfer.
- **Packed quantization:**
  - Stimulus: lanes 0..3 = -5, 40, 1023, 1024; Shift=2; Out_mode=1.
  - Response: word 0 = 0xFFFF0A00.
  - Frame has exactly 4 words; Out_last on word 3.
- **Shift boundaries:**
  - Shift=0 with lane = 255 gives 0xFF; lane = 256 gives 0xFF (saturated).
  - Shift=31 with lane = 0x7FFFFFFF gives 0x00.
- **Back-to-back frames:**
  - Stimulus: Result_valid on the final-transfer cycle of frame A, Out_ready=1.
  - Response: frame B word 0 appears the next cycle with no Out_valid gap and no Overrun.
- **Overrun:**
  - Stimulus: Result_valid in SEND at word index 5 with Out_ready=0.
  - Response: Overrun pulses 1 cycle; frame A completes unchanged with 16 words; the second pulse's data never appears.

Source files
------------

// File: rtl/array_result_drain.sv
// array_result_drain: captures PE array accumulator lanes and streams them raw or ReLU-quantized over valid/ready
module array_result_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 4*DATA_WIDTH,
  parameter int LANES      = 16
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [LANES*ACC_WIDTH-1:0] Array_Output,
  input  logic                       Result_valid,
  input  logic                       Out_mode,
  input  logic [4:0]                 Shift,
  output logic [ACC_WIDTH-1:0]       Out_data,
  output logic                       Out_valid,
  input  logic                       Out_ready,
  output logic                       Out_last,
  output logic                       Busy,
  output logic                       Overrun
);
  localparam int IW = $clog2(LANES);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [ACC_WIDTH-1:0] lane_q [LANES];
  logic mode_q;
  logic [4:0] shift_q;
  logic [IW-1:0] idx;
  logic last, xfer, capture, overrun_d;
  logic [ACC_WIDTH-1:0] pk_w;

  function automatic logic [DATA_WIDTH-1:0] quant(input logic [ACC_WIDTH-1:0] v, input logic [4:0] s);
    logic [ACC_WIDTH-1:0] t;
    t = v >> s;
    return v[ACC_WIDTH-1] ? '0 : (|(t >> DATA_WIDTH)) ? '1 : t[DATA_WIDTH-1:0];
  endfunction

  // packed word k gathers lanes 4k..4k+3, lowest lane in the low byte
  always_comb begin
    pk_w = '0;
    for (int j = 0; j < 4; j++)
      pk_w[j*DATA_WIDTH +: DATA_WIDTH] = quant(lane_q[IW'({idx, 2'(j)})], shift_q);
  end

  always_comb begin
    Out_valid = state == SEND;
    Busy      = Out_valid;
    last      = mode_q ? idx == IW'(LANES/4-1) : idx == IW'(LANES-1);
    xfer      = Out_valid && Out_ready;
    capture   = Result_valid && (!Out_valid || (xfer && last));
    overrun_d = Result_valid && Out_valid && !(xfer && last);
    state_nxt = capture ? SEND : (xfer && last) ? IDLE : state;
    Out_last  = Out_valid && last;
    Out_data  = !Out_valid ? '0 : mode_q ? pk_w : lane_q[idx];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      idx     <= '0;
      Overrun <= 1'b0;
      mode_q  <= 1'b0;
      shift_q <= '0;
      lane_q  <= '{default: '0};
    end else begin
      state   <= state_nxt;
      Overrun <= overrun_d;
      if (capture) begin
        idx     <= '0;
        mode_q  <= Out_mode;
        shift_q <= Shift;
        for (int i = 0; i < LANES; i++)
          lane_q[i] <= Array_Output[i*ACC_WIDTH +: ACC_WIDTH];
      end else if (xfer) begin
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_array_result_drain.sv
// tb_array_result_drain: directed scoreboard bench for array_result_drain
module tb_array_result_drain;
  logic Clk = 0, Rst = 1;
  logic [16*32-1:0] Array_Output = '0;
  logic Result_valid = 0, Out_mode = 0, Out_ready = 0;
  logic [4:0] Shift = 0;
  logic [31:0] Out_data;
  logic Out_valid, Out_last, Busy, Overrun;
  int total = 0, bad = 0;
  logic [32:0] exp_q[$];
  logic [32:0] held, e;
  logic stalled = 0;
  logic [31:0] ln [16];

  array_result_drain dut (
    .Clk(Clk), .Rst(Rst), .Array_Output(Array_Output), .Result_valid(Result_valid),
    .Out_mode(Out_mode), .Shift(Shift), .Out_data(Out_data), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Out_last(Out_last), .Busy(Busy), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] q8(input logic [31:0] v, input logic [4:0] s);
    logic [31:0] t;
    t = v >> s;
    if ($signed(v) < 0) return 8'd0;
    if (t > 32'd255) return 8'd255;
    return t[7:0];
  endfunction

  task automatic capture(input logic mode, input logic [4:0] sh, input logic push);
    for (int i = 0; i < 16; i++) Array_Output[i*32 +: 32] = ln[i];
    Result_valid = 1; Out_mode = mode; Shift = sh;
    if (push) begin
      if (!mode)
        for (int k = 0; k < 16; k++) exp_q.push_back({k == 15, ln[k]});
      else
        for (int k = 0; k < 4; k++)
          exp_q.push_back({k == 3, q8(ln[4*k+3], sh), q8(ln[4*k+2], sh), q8(ln[4*k+1], sh), q8(ln[4*k], sh)});
    end
    tick();
    Result_valid = 0; Out_mode = ~mode; Shift = ~sh;
    Array_Output = '1;
  endtask

  task automatic drain(input logic toggle);
    int n;
    n = 0;
    Out_ready = 1;
    while ((Busy || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
      if (toggle) Out_ready = ~Out_ready;
    end
    chk("drain_done", 32'(exp_q.size() == 0 && !Busy), 1);
  endtask

  // scoreboard: a word is consumed at the edge following a negedge with valid && ready
  always @(negedge Clk) begin
    if (Rst) stalled = 0;
    else if (!Out_valid) chk("idle_data", Out_data, 0);
    else begin
      if (stalled) begin
        chk("hold_data", Out_data, held[31:0]);
        chk("hold_last", 32'(Out_last), 32'(held[32]));
      end
      if (Out_ready) begin
        chk("word_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("word_data", Out_data, e[31:0]);
          chk("word_last", 32'(Out_last), 32'(e[32]));
        end
        stalled = 0;
      end else begin
        held = {Out_last, Out_data};
        stalled = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    chk("rst_valid", 32'(Out_valid), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_last", 32'(Out_last), 0);
    chk("rst_data", Out_data, 0);
    chk("rst_overrun", 32'(Overrun), 0);
    Rst = 0;
    Out_ready = 1;
    tick();
    chk("idle_ready_ignored", 32'(Out_valid), 0);
    // reset mid-frame
    for (int i = 0; i < 16; i++) ln[i] = 1000 + i;
    capture(0, 0, 1);
    chk("cap_latency", 32'(Out_valid), 1);
    tick(); tick(); tick();
    chk("mid_word3", Out_data, 1003);
    Out_ready = 0;
    Rst = 1;
    #1;
    chk("mrst_valid", 32'(Out_valid), 0);
    chk("mrst_busy", 32'(Busy), 0);
    chk("mrst_last", 32'(Out_last), 0);
    chk("mrst_data", Out_data, 0);
    exp_q.delete();
    tick();
    Rst = 0;
    Out_ready = 1;
    tick(); tick();
    chk("post_rst_quiet", 32'(Out_valid), 0);
    for (int i = 0; i < 16; i++) ln[i] = 2000 + i;
    capture(0, 0, 1);
    chk("restart_lane0", Out_data, 2000);
    drain(0);
    // raw drain with stalls
    for (int i = 0; i < 16; i++) ln[i] = 1000 + i;
    capture(0, 0, 1);
    drain(1);
    chk("raw_busy_fall", 32'(Busy), 0);
    // packed quantization
    ln[0] = -5; ln[1] = 40; ln[2] = 1023; ln[3] = 1024;
    for (int i = 4; i < 16; i++) ln[i] = $urandom;
    capture(1, 2, 1);
    chk("pk_word0", Out_data, 32'hFFFF0A00);
    drain(0);
    // shift boundaries
    ln[0] = 255; ln[1] = 256; ln[2] = 0; ln[3] = 32'h8000_0000;
    capture(1, 0, 1);
    chk("sh0_word0", Out_data, 32'h0000FFFF);
    drain(1);
    for (int i = 0; i < 16; i++) ln[i] = 32'h7FFF_FFFF;
    capture(1, 31, 1);
    chk("sh31_word0", Out_data, 32'h0);
    drain(0);
    // back-to-back frames: raw A then packed B on A's final transfer
    for (int i = 0; i < 16; i++) ln[i] = $urandom;
    Out_ready = 1;
    capture(0, 0, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("b2b_last_a", 32'(Out_last), 1);
    for (int i = 0; i < 16; i++) ln[i] = $urandom_range(0, 4000);
    capture(1, 3, 1);
    chk("b2b_no_gap", 32'(Out_valid), 1);
    chk("b2b_word0", Out_data, {q8(ln[3], 3), q8(ln[2], 3), q8(ln[1], 3), q8(ln[0], 3)});
    chk("b2b_no_overrun", 32'(Overrun), 0);
    drain(0);
    // overrun at word index 5 with Out_ready low
    for (int i = 0; i < 16; i++) ln[i] = 500 + 3*i;
    Out_ready = 1;
    capture(0, 0, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("ovr_idx5", Out_data, 515);
    Out_ready = 0;
    for (int i = 0; i < 16; i++) ln[i] = 32'hDEAD_0000 + i;
    capture(1, 1, 0);
    chk("ovr_pulse", 32'(Overrun), 1);
    chk("ovr_untouched", Out_data, 515);
    tick();
    chk("ovr_one_cycle", 32'(Overrun), 0);
    drain(0);
    tick(); tick();
    chk("end_idle", 32'(Out_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
